// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP operand/result path slices.
package dsp_pkg;

    // Occupancy state of a two-entry skid slice; the encoding doubles as the
    // entry count, which keeps the level decode trivial.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    // Number of words a slice can hold (main register plus skid register).
    localparam int SKID_DEPTH = 2;

    // Number of words held in a given state.
    function automatic logic [1:0] skid_level(skid_state_t s);
        logic [1:0] lvl;
        case (s)
            EMPTY:   lvl = 2'd0;
            BUSY:    lvl = 2'd1;
            FULL:    lvl = 2'(SKID_DEPTH);
            default: lvl = 2'd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready register slice with a skid buffer.
// The main register always drives out_data; the skid register catches the
// one extra word that arrives while the consumer stalls, so in_ready never
// depends combinationally on out_ready.
module pipe_skid_stage
    import dsp_pkg::*;
#(
    parameter int D_WIDTH = 18,
    parameter bit BYPASS  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [1:0]         level
);

    generate
        if (BYPASS) begin : g_bypass

            // Straight wires: no storage, handshake passes through untouched.
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst_n, flush};

            // Forward the producer side directly to the consumer side.
            always_comb begin
                out_valid = in_valid;
                out_data  = in_data;
                in_ready  = out_ready;
                level     = 2'd0;
            end

        end else begin : g_slice

            skid_state_t        state_q, state_d;
            logic [D_WIDTH-1:0] main_q,  main_d;
            logic [D_WIDTH-1:0] skid_q,  skid_d;
            logic               in_ready_int;
            logic               out_valid_int;
            logic               in_fire;
            logic               out_fire;

            // Handshake qualifiers; in_ready only looks at local state, reset and flush.
            always_comb begin
                in_ready_int  = rst_n & ~flush & (state_q != FULL);
                out_valid_int = (state_q != EMPTY);
                in_fire       = in_valid & in_ready_int;
                out_fire      = out_valid_int & out_ready;
            end

            // State register; reset discards every held word immediately.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            // Next-state logic; flush overrides every other transition.
            always_comb begin
                state_d = state_q;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d = BUSY;
                            end
                        end
                        BUSY: begin
                            if (in_fire && !out_fire) begin
                                state_d = FULL;
                            end else if (!in_fire && out_fire) begin
                                state_d = EMPTY;
                            end
                        end
                        FULL: begin
                            if (out_fire) begin
                                state_d = BUSY;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            // Datapath: load main on the way in, park in skid when the consumer stalls.
            always_comb begin
                main_d = main_q;
                skid_d = skid_q;
                if (flush) begin
                    main_d = '0;
                    skid_d = '0;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                main_d = in_data;
                            end
                        end
                        BUSY: begin
                            if (in_fire && !out_fire) begin
                                skid_d = in_data;
                            end else if (in_fire && out_fire) begin
                                main_d = in_data;
                            end
                        end
                        FULL: begin
                            if (out_fire) begin
                                main_d = skid_q;
                            end
                        end
                        default: begin
                            main_d = '0;
                            skid_d = '0;
                        end
                    endcase
                end
            end

            // Output decode straight from the registered state.
            always_comb begin
                out_valid = out_valid_int;
                out_data  = main_q;
                in_ready  = in_ready_int;
                level     = skid_level(state_q);
            end

        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: a reference queue tracks every
// accepted word and is compared against the slice whenever it presents data.
module tb_pipe_skid_stage;

    localparam int W = 18;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   level;

    logic         b_in_valid;
    logic         b_in_ready;
    logic [W-1:0] b_in_data;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_level;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;
    int           vectors;
    int           miscompares;

    pipe_skid_stage #(.D_WIDTH(W), .BYPASS(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level)
    );

    pipe_skid_stage #(.D_WIDTH(W), .BYPASS(1'b1)) dut_byp (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_data (b_out_data),
        .level    (b_level)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle: at the falling edge check the slice against the
    // reference queue, record the handshakes that the coming rising edge
    // will perform, then return 1 unit after that rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            vectors++;
            if (level !== 2'(exp_q.size())) begin
                miscompares++;
                $display("[TB] FAIL level: got %0d expected %0d", level, exp_q.size());
            end
            vectors++;
            if (out_valid !== (exp_q.size() != 0)) begin
                miscompares++;
                $display("[TB] FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
            end
            vectors++;
            if (in_ready !== ((exp_q.size() < 2) && !flush)) begin
                miscompares++;
                $display("[TB] FAIL in_ready: got %b expected %b", in_ready,
                         (exp_q.size() < 2) && !flush);
            end
            if (exp_q.size() != 0) begin
                vectors++;
                if (out_data !== exp_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL out_data: got %h expected %h", out_data, exp_q[0]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
            end
            if (flush) begin
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset values are forced asynchronously and released without a word offered.
    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        exp_q.delete();
        #3;
        vectors++;
        if ({out_valid, level, in_ready, out_data} !== {1'b0, 2'd0, 1'b0, {W{1'b0}}}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got v=%b l=%0d r=%b d=%h expected all zero",
                     out_valid, level, in_ready, out_data);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // Continuous stream with the consumer always ready: no gaps, never above one entry.
    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== W'(i) || level !== 2'd1) begin
                miscompares++;
                $display("[TB] FAIL stream_word: got v=%b d=%h l=%0d expected v=1 d=%h l=1",
                         out_valid, out_data, level, W'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    // Two words while stalled fill the slice; draining releases them in order.
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 18'h2AAAA;
        tick();
        in_data = 18'h15555;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 18'h2AAAA) begin
            miscompares++;
            $display("[TB] FAIL full_hold: got l=%0d r=%b d=%h expected l=2 r=0 d=2aaaa",
                     level, in_ready, out_data);
        end
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_data !== 18'h15555 || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drain_second: got v=%b d=%h expected v=1 d=15555", out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_empty: got v=%b expected v=0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    // Random producer/consumer activity checked cycle by cycle against the queue.
    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        vectors++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL random_drain: got v=%b pending=%0d expected v=0 pending=0",
                     out_valid, exp_q.size());
        end
        out_ready = 1'b0;
    endtask

    // Flush while full with a word offered: everything is cleared and nothing accepted.
    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 18'h00AA1;
        tick();
        in_data = 18'h00AA2;
        tick();
        in_data = 18'h01234;
        flush   = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL flush_clear: got l=%0d v=%b d=%h expected l=0 v=0 d=0",
                     level, out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_accept: got v=%b expected v=0", out_valid);
        end
    endtask

    // Asynchronous reset while full, then a clean word after release.
    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 18'h00BB1;
        tick();
        in_data = 18'h00BB2;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        vectors++;
        if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v=%b l=%0d r=%b expected all 0",
                     out_valid, level, in_ready);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        in_valid  = 1'b1;
        in_data   = 18'h00123;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 18'h00123) begin
            miscompares++;
            $display("[TB] FAIL post_reset_word: got v=%b d=%h expected v=1 d=00123", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    // Bypass build is pure wiring: same-cycle data, ready mirrors the consumer.
    task automatic test_bypass();
        b_in_valid  = 1'b1;
        b_in_data   = 18'h3FFFF;
        b_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_out_ready = i[0];
            #2;
            vectors++;
            if (b_out_data !== 18'h3FFFF || b_out_valid !== 1'b1 ||
                b_in_ready !== b_out_ready || b_level !== 2'd0) begin
                miscompares++;
                $display("[TB] FAIL bypass: got d=%h v=%b r=%b l=%0d expected d=3ffff v=1 r=%b l=0",
                         b_out_data, b_out_valid, b_in_ready, b_level, b_out_ready);
            end
        end
        b_in_valid = 1'b0;
        #1;
        vectors++;
        if (b_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bypass_valid: got %b expected 0", b_out_valid);
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
